// File: rtl/pio_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_arbiter_if
// Description : Requester command bundle, PIO command bus and PULL response
//               channel shared by the sequencers, the arbiter and the pio.
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_cmd_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_lock;
    logic [2*NREQ-1:0]  req_mindex;
    logic [6*NREQ-1:0]  req_action;
    logic [32*NREQ-1:0] req_din;
    logic [5*NREQ-1:0]  req_index;
    logic [NREQ-1:0]    gnt;

    logic [1:0]         pio_mindex;
    logic [5:0]         pio_action;
    logic [31:0]        pio_din;
    logic [4:0]         pio_index;
    logic [31:0]        pio_dout;
    logic [3:0]         tx_full;
    logic [3:0]         rx_empty;

    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;

    // The master side is the environment: requesters plus the pio instance.
    modport master (
        output req, req_lock, req_mindex, req_action, req_din, req_index,
        input  gnt,
        input  pio_mindex, pio_action, pio_din, pio_index,
        output pio_dout, tx_full, rx_empty,
        input  rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, req_lock, req_mindex, req_action, req_din, req_index,
        output gnt,
        output pio_mindex, pio_action, pio_din, pio_index,
        input  pio_dout, tx_full, rx_empty,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/pio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_arbiter
// Description : Round-robin arbiter with lock sharing one PIO command bus,
//               with FIFO-aware throttling and routed PULL responses.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_cmd_arbiter #(
    parameter int         NREQ     = 4,
    parameter logic [5:0] PUSH_ACT = 6'd4,
    parameter logic [5:0] PULL_ACT = 6'd5
) (
    input  wire logic        clk_25mhz,
    input  wire logic        reset,
    pio_cmd_arbiter_if.slave bus
);
    localparam int             IDW       = (NREQ > 2) ? 2 : 1;
    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [5:0]      w_act [NREQ];
    logic [1:0]      w_mi  [NREQ];
    logic [31:0]     w_din [NREQ];
    logic [4:0]      w_idx [NREQ];
    logic [NREQ-1:0] w_elig;

    logic [1:0]      r_mindex;
    logic [5:0]      r_action;
    logic [31:0]     r_din;
    logic [4:0]      r_index;
    logic [IDW-1:0]  r_last_grant;
    logic            r_lock_valid;
    logic [IDW-1:0]  r_lock_id;
    logic            r_p0_valid;
    logic [IDW-1:0]  r_p0_id;
    logic            r_p1_valid;
    logic [IDW-1:0]  r_p1_id;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_data;

    logic            w_lock_hold;
    logic            w_win_valid;
    logic [IDW-1:0]  w_win_id;
    logic [IDW-1:0]  w_cand;
    int              w_pos;
    logic [NREQ-1:0] w_gnt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic w_push_blk;
        logic w_pull_blk;

        assign w_act[gi] = bus.req_action[6*gi +: 6];
        assign w_mi[gi]  = bus.req_mindex[2*gi +: 2];
        assign w_din[gi] = bus.req_din[32*gi +: 32];
        assign w_idx[gi] = bus.req_index[5*gi +: 5];

        // The FIFO flags lag one cycle behind the bus, so a matching command
        // already on the bus counts as filling/draining that FIFO.
        assign w_push_blk = (w_act[gi] == PUSH_ACT) &&
                            (bus.tx_full[w_mi[gi]] ||
                             ((r_action == PUSH_ACT) && (r_mindex == w_mi[gi])));
        assign w_pull_blk = (w_act[gi] == PULL_ACT) &&
                            (bus.rx_empty[w_mi[gi]] ||
                             ((r_action == PULL_ACT) && (r_mindex == w_mi[gi])));

        assign w_elig[gi] = bus.req[gi] & ~(w_push_blk | w_pull_blk);
    end

    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = '0;
        w_cand      = '0;
        w_pos       = 0;
        w_lock_hold = r_lock_valid && bus.req[r_lock_id];
        if (w_lock_hold) begin
            // A blocked lock holder stalls the bus rather than yield it.
            w_win_valid = w_elig[r_lock_id];
            w_win_id    = r_lock_id;
        end else begin
            // Walk backwards so the nearest requester after last_grant wins.
            for (int k = NREQ; k >= 1; k--) begin
                w_pos = int'(r_last_grant) + k;
                if (w_pos >= NREQ) begin
                    w_pos = w_pos - NREQ;
                end
                w_cand = IDW'(w_pos);
                if (w_elig[w_cand]) begin
                    w_win_valid = 1'b1;
                    w_win_id    = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_win_valid && !reset) begin
            w_gnt[w_win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_mindex     <= '0;
            r_action     <= '0;
            r_din        <= '0;
            r_index      <= '0;
            r_last_grant <= c_last_id;
            r_lock_valid <= 1'b0;
            r_lock_id    <= '0;
            r_p0_valid   <= 1'b0;
            r_p0_id      <= '0;
            r_p1_valid   <= 1'b0;
            r_p1_id      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
        end else begin
            if (w_win_valid) begin
                r_mindex     <= w_mi[w_win_id];
                r_action     <= w_act[w_win_id];
                r_din        <= w_din[w_win_id];
                r_index      <= w_idx[w_win_id];
                r_last_grant <= w_win_id;
                r_lock_valid <= bus.req_lock[w_win_id];
                r_lock_id    <= w_win_id;
            end else begin
                r_action <= '0;
                if (r_lock_valid && !bus.req[r_lock_id]) begin
                    r_lock_valid <= 1'b0;
                end
            end

            // PULL tracking: p0 aligns with the bus cycle, p1 with pio_dout.
            r_p0_valid  <= w_win_valid && (w_act[w_win_id] == PULL_ACT);
            r_p0_id     <= w_win_id;
            r_p1_valid  <= r_p0_valid;
            r_p1_id     <= r_p0_id;
            r_rsp_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_rsp_id   <= r_p1_id;
                r_rsp_data <= bus.pio_dout;
            end
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.pio_mindex = r_mindex;
    assign bus.pio_action = r_action;
    assign bus.pio_din    = r_din;
    assign bus.pio_index  = r_index;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = 2'(r_rsp_id);
    assign bus.rsp_data   = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_pio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_cmd_arbiter
// Description : Directed self-checking bench for pio_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_cmd_arbiter;
    logic clk_25mhz = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    pio_cmd_arbiter_if #(.NREQ(4)) bus ();

    pio_cmd_arbiter #(
        .NREQ    (4),
        .PUSH_ACT(6'd4),
        .PULL_ACT(6'd5)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .reset    (reset),
        .bus      (bus)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    function automatic logic [31:0] dout_for(input logic [1:0] m);
        return (m == 2'd2) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(m));
    endfunction

    // pio model: RX data appears one cycle after a PULL is presented
    always @(posedge clk_25mhz) begin
        bus.pio_dout <= (bus.pio_action == 6'd5) ? dout_for(bus.pio_mindex) : 32'h0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_25mhz);
        #2;
    endtask

    task automatic settle();
        #10;
    endtask

    task automatic clear_inputs();
        bus.req        = '0;
        bus.req_lock   = '0;
        bus.req_mindex = '0;
        bus.req_action = '0;
        bus.req_din    = '0;
        bus.req_index  = '0;
        bus.tx_full    = '0;
        bus.rx_empty   = '0;
    endtask

    task automatic set_cmd(input int i, input logic [5:0] act, input logic [1:0] mi,
                           input logic [31:0] din, input logic [4:0] idx, input logic lk);
        bus.req[i]              = 1'b1;
        bus.req_lock[i]         = lk;
        bus.req_action[6*i +: 6] = act;
        bus.req_mindex[2*i +: 2] = mi;
        bus.req_din[32*i +: 32]  = din;
        bus.req_index[5*i +: 5]  = idx;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        bus.req = 4'b1111;
        settle();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
        checks++; if (bus.pio_action !== 6'd0) begin errors++; $display("FAIL reset_action got %0d want 0", bus.pio_action); end
        checks++; if (bus.pio_mindex !== 2'd0) begin errors++; $display("FAIL reset_mindex got %0d want 0", bus.pio_mindex); end
        checks++; if (bus.pio_din !== 32'd0) begin errors++; $display("FAIL reset_din got %h want 0", bus.pio_din); end
        checks++; if (bus.pio_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", bus.pio_index); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [4:0] exp_idx;
        do_reset();
        for (int i = 0; i < 4; i++) set_cmd(i, 6'd1, 2'(i), 32'h100 + 32'(i), 5'(10 + i), 1'b0);
        for (int k = 0; k < 5; k++) begin
            settle();
            exp_gnt = 4'b0001 << (k % 4);
            checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", k, bus.gnt, exp_gnt); end
            if (k > 0) begin
                exp_idx = 5'(10 + ((k - 1) % 4));
                checks++; if (bus.pio_action !== 6'd1) begin errors++; $display("FAIL rr_action cycle %0d got %0d want 1", k, bus.pio_action); end
                checks++; if (bus.pio_index !== exp_idx) begin errors++; $display("FAIL rr_index cycle %0d got %0d want %0d", k, bus.pio_index, exp_idx); end
            end
            tick();
        end
        bus.req = '0;
        settle();
        checks++; if (bus.pio_index !== 5'd10 || bus.pio_din !== 32'h100) begin errors++; $display("FAIL rr_last_issue got idx %0d din %h want 10 00000100", bus.pio_index, bus.pio_din); end
        tick();
        settle();
        checks++; if (bus.pio_action !== 6'd0) begin errors++; $display("FAIL rr_idle_action got %0d want 0", bus.pio_action); end
        checks++; if (bus.pio_index !== 5'd10) begin errors++; $display("FAIL rr_hold_index got %0d want 10", bus.pio_index); end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [3:0] exp_gnt;
        do_reset();
        set_cmd(1, 6'd1, 2'd0, 32'h0, 5'd31, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            set_cmd(0, 6'd1, 2'd0, 32'(k), 5'(k), (k < 9));
            settle();
            exp_gnt = (k < 10) ? 4'b0001 : 4'b0010;
            checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL lock_gnt cycle %0d got %b want %b", k, bus.gnt, exp_gnt); end
            if (k > 0) begin
                checks++; if (bus.pio_index !== 5'(k - 1)) begin errors++; $display("FAIL lock_index cycle %0d got %0d want %0d", k, bus.pio_index, k - 1); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock_blocked();
        do_reset();
        set_cmd(0, 6'd1, 2'd0, 32'h0, 5'd1, 1'b1);
        set_cmd(1, 6'd1, 2'd0, 32'h0, 5'd2, 1'b0);
        settle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL lockblk_first got %b want 0001", bus.gnt); end
        tick();
        set_cmd(0, 6'd4, 2'd0, 32'h55, 5'd3, 1'b1);
        bus.tx_full = 4'b0001;
        settle();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL lockblk_stall got %b want 0000", bus.gnt); end
        tick();
        bus.req[0] = 1'b0;
        settle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL lockblk_release got %b want 0010", bus.gnt); end
        checks++; if (bus.pio_action !== 6'd0) begin errors++; $display("FAIL lockblk_idle got %0d want 0", bus.pio_action); end
        tick();
        clear_inputs();
    endtask

    task automatic test_push_throttle();
        do_reset();
        set_cmd(2, 6'd4, 2'd1, 32'hA5, 5'd0, 1'b0);
        bus.tx_full = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL push_full_gnt cycle %0d got %b want 0000", k, bus.gnt); end
            checks++; if (bus.pio_action !== 6'd0) begin errors++; $display("FAIL push_full_action cycle %0d got %0d want 0", k, bus.pio_action); end
            tick();
        end
        bus.tx_full = 4'b0000;
        settle();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL push_gnt got %b want 0100", bus.gnt); end
        tick();
        bus.req = '0;
        settle();
        checks++; if (bus.pio_action !== 6'd4 || bus.pio_din !== 32'h0000_00A5 || bus.pio_mindex !== 2'd1) begin
            errors++; $display("FAIL push_issue got act %0d din %h m %0d want 4 000000a5 1", bus.pio_action, bus.pio_din, bus.pio_mindex);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back_push();
        do_reset();
        set_cmd(1, 6'd4, 2'd0, 32'h1, 5'd0, 1'b0);
        set_cmd(3, 6'd4, 2'd0, 32'h3, 5'd0, 1'b0);
        settle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL b2b_first got %b want 0010", bus.gnt); end
        tick();
        bus.req[1] = 1'b0;
        settle();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL b2b_guard got %b want 0000", bus.gnt); end
        checks++; if (bus.pio_action !== 6'd4 || bus.pio_din !== 32'h1) begin errors++; $display("FAIL b2b_issue1 got act %0d din %h want 4 00000001", bus.pio_action, bus.pio_din); end
        tick();
        settle();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL b2b_second got %b want 1000", bus.gnt); end
        checks++; if (bus.pio_action !== 6'd0) begin errors++; $display("FAIL b2b_gap got %0d want 0", bus.pio_action); end
        tick();
        bus.req[3] = 1'b0;
        settle();
        checks++; if (bus.pio_action !== 6'd4 || bus.pio_din !== 32'h3) begin errors++; $display("FAIL b2b_issue2 got act %0d din %h want 4 00000003", bus.pio_action, bus.pio_din); end
        tick();
        clear_inputs();
    endtask

    task automatic test_pull();
        do_reset();
        set_cmd(3, 6'd5, 2'd2, 32'h0, 5'd0, 1'b0);
        bus.rx_empty = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL pull_empty_gnt cycle %0d got %b want 0000", k, bus.gnt); end
            tick();
        end
        bus.rx_empty = 4'b0000;
        settle();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL pull_gnt got %b want 1000", bus.gnt); end
        tick();
        bus.req = '0;
        settle();
        checks++; if (bus.pio_action !== 6'd5 || bus.pio_mindex !== 2'd2) begin errors++; $display("FAIL pull_issue got act %0d m %0d want 5 2", bus.pio_action, bus.pio_mindex); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL pull_early1 got %b want 0", bus.rsp_valid); end
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL pull_early2 got %b want 0", bus.rsp_valid); end
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL pull_rsp got v %b id %0d data %h want 1 3 deadbeef", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL pull_pulse got %b want 0", bus.rsp_valid); end
        clear_inputs();
    endtask

    task automatic test_back_to_back_pull();
        do_reset();
        set_cmd(0, 6'd5, 2'd2, 32'h0, 5'd0, 1'b0);
        set_cmd(1, 6'd5, 2'd3, 32'h0, 5'd0, 1'b0);
        settle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL b2bpull_first got %b want 0001", bus.gnt); end
        tick();
        bus.req[0] = 1'b0;
        settle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL b2bpull_second got %b want 0010", bus.gnt); end
        tick();
        clear_inputs();
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL b2bpull_rsp0 got v %b id %0d data %h want 1 0 deadbeef", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'h1000_0003) begin
            errors++; $display("FAIL b2bpull_rsp1 got v %b id %0d data %h want 1 1 10000003", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        settle();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2bpull_end got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cmd(1, 6'd5, 2'd2, 32'h0, 5'd0, 1'b0);
        settle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_gnt got %b want 0010", bus.gnt); end
        tick();
        clear_inputs();
        reset = 1'b1;
        settle();
        checks++; if (bus.pio_action !== 6'd5) begin errors++; $display("FAIL midrst_issue got %0d want 5", bus.pio_action); end
        tick();
        reset = 1'b0;
        settle();
        checks++; if (bus.pio_action !== 6'd0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_clear got act %0d v %b want 0 0", bus.pio_action, bus.rsp_valid); end
        tick();
        for (int i = 0; i < 4; i++) set_cmd(i, 6'd1, 2'd0, 32'h0, 5'(20 + i), 1'b0);
        settle();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got %b want 0", bus.rsp_valid); end
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL midrst_next_gnt got %b want 0001", bus.gnt); end
        tick();
        clear_inputs();
        settle();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp2 got %b want 0", bus.rsp_valid); end
        checks++; if (bus.pio_action !== 6'd1 || bus.pio_index !== 5'd20) begin errors++; $display("FAIL midrst_issue2 got act %0d idx %0d want 1 20", bus.pio_action, bus.pio_index); end
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_lock();
        test_lock_blocked();
        test_push_throttle();
        test_back_to_back_push();
        test_pull();
        test_back_to_back_pull();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
